// File: rtl/pd_pkg.sv
// Shared types for the windowed phase detector.
// State encoding, vote encoding and accumulator width helper.
package pd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } pd_state_t;

    typedef logic signed [1:0] vote_t;

    localparam vote_t VOTE_LEAD = 2'sb01;
    localparam vote_t VOTE_LAG  = 2'sb11;
    localparam vote_t VOTE_NONE = 2'sb00;

    function automatic int cw_of(input int win);
        return $clog2(win + 1) + 1;
    endfunction

endpackage

// File: rtl/pd_tap_classifier.sv
// Classifies one set of clk_out tap samples as lead, lag or in-band.
// Adjacent-tap XOR counts transitions: none = clean lead/lag.
module pd_tap_classifier
    import pd_pkg::*;
#(
    parameter int NTAP = 4
) (
    input  logic [NTAP-1:0] taps,
    output vote_t           vote
);

    logic [NTAP-2:0] diff;

    assign diff = taps[NTAP-1:1] ^ taps[NTAP-2:0];

    always_comb begin
        vote = VOTE_NONE;
        unique case (1'b1)
            (diff == '0) && taps[0]:  vote = VOTE_LEAD;
            (diff == '0) && !taps[0]: vote = VOTE_LAG;
            // single edge sits inside the tap span: in band
            $onehot(diff):            vote = VOTE_NONE;
            default:                  vote = VOTE_NONE;
        endcase
    end

endmodule

// File: rtl/pd_window_vote.sv
// Windowed-vote DLL phase detector with lock hysteresis.
// Strobe on DIV_M rise; one UP/DN pulse per decisive window.
module pd_window_vote
    import pd_pkg::*;
#(
    parameter  int NTAP      = 4,
    parameter  int WIN       = 8,
    parameter  int THRESH    = 4,
    parameter  int THRESH_LK = 6,
    parameter  int LOCK_WIN  = 4,
    localparam int CW        = cw_of(WIN)
) (
    input  logic                 clk_ext,
    input  logic                 Reset_PD,
    input  logic                 DIV_M,
    input  logic [NTAP-1:0]      clk_out_taps,
    input  logic                 hold,
    output logic                 COMP,
    output logic                 UP,
    output logic                 DN,
    output logic                 LOCK,
    output logic signed [CW-1:0] score
);

    localparam int CNTW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int QW   = $clog2(LOCK_WIN + 1);

    localparam logic [CNTW-1:0]      CNT_LAST  = CNTW'(WIN - 1);
    localparam logic [QW-1:0]        QUIET_MAX = QW'(LOCK_WIN);
    localparam logic signed [CW-1:0] THR_A     = CW'(THRESH);
    localparam logic signed [CW-1:0] THR_L     = CW'(THRESH_LK);

    pd_state_t              state, state_n;
    logic [QW-1:0]          quiet, quiet_n;
    logic [CNTW-1:0]        cnt;
    logic signed [CW-1:0]   acc, sum, thr;
    logic                   div_q, strobe, win_end;
    logic                   up_n, dn_n;
    vote_t                  vote;

    pd_tap_classifier #(.NTAP(NTAP)) u_cls (
        .taps (clk_out_taps),
        .vote (vote)
    );

    assign strobe  = DIV_M & ~div_q & ~hold;
    assign win_end = strobe && (cnt == CNT_LAST);
    assign sum     = acc + $signed({{(CW-2){vote[1]}}, vote});
    assign thr     = (state == LOCKED) ? THR_L : THR_A;
    assign LOCK    = (state == LOCKED);

    always_comb begin
        up_n    = win_end && (sum >= thr);
        dn_n    = win_end && (sum <= -thr);
        state_n = state;
        quiet_n = quiet;
        unique case (state)
            IDLE: begin
                if (strobe) state_n = ACQUIRE;
            end
            ACQUIRE: begin
                if (up_n || dn_n) begin
                    quiet_n = '0;
                end else if (win_end) begin
                    quiet_n = (quiet == QUIET_MAX) ? quiet : quiet + 1'b1;
                    if (quiet_n == QUIET_MAX) state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (up_n || dn_n) begin
                    state_n = ACQUIRE;
                    quiet_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_ext) begin
        if (Reset_PD) begin
            state <= IDLE;
            quiet <= '0;
        end else begin
            state <= state_n;
            quiet <= quiet_n;
        end
    end

    // edge register resets high so a DIV_M already high is not a strobe
    always_ff @(posedge clk_ext) begin
        if (Reset_PD) begin
            div_q <= 1'b1;
            cnt   <= '0;
            acc   <= '0;
            score <= '0;
            COMP  <= 1'b0;
            UP    <= 1'b0;
            DN    <= 1'b0;
        end else begin
            div_q <= DIV_M;
            UP    <= up_n;
            DN    <= dn_n;
            if (strobe) begin
                COMP <= clk_out_taps[NTAP/2];
                if (win_end) begin
                    score <= sum;
                    acc   <= '0;
                    cnt   <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pd_window_vote.sv
// Directed bench for pd_window_vote with default parameters.
// Expected values are hand-computed per step.
module tb_pd_window_vote;
    import pd_pkg::*;

    logic              clk_ext;
    logic              Reset_PD;
    logic              DIV_M;
    logic [3:0]        clk_out_taps;
    logic              hold;
    logic              COMP;
    logic              UP;
    logic              DN;
    logic              LOCK;
    logic signed [4:0] score;

    int n_cmp = 0;
    int n_bad = 0;
    int ups   = 0;
    int dns   = 0;
    logic up_s, dn_s, lk_s;

    pd_window_vote dut (
        .clk_ext      (clk_ext),
        .Reset_PD     (Reset_PD),
        .DIV_M        (DIV_M),
        .clk_out_taps (clk_out_taps),
        .hold         (hold),
        .COMP         (COMP),
        .UP           (UP),
        .DN           (DN),
        .LOCK         (LOCK),
        .score        (score)
    );

    initial clk_ext = 1'b0;
    always #5 clk_ext = ~clk_ext;

    task automatic tick;
        @(posedge clk_ext);
        #1;
        ups += int'(UP);
        dns += int'(DN);
    endtask

    task automatic strobe(input logic [3:0] t);
        DIV_M        = 1'b1;
        clk_out_taps = t;
        tick();
        up_s  = UP;
        dn_s  = DN;
        lk_s  = LOCK;
        DIV_M = 1'b0;
        tick();
    endtask

    task automatic strobes(input int n, input logic [3:0] t);
        for (int i = 0; i < n; i++) strobe(t);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_PD     = 1'b1;
        DIV_M        = 1'b1;
        hold         = 1'b0;
        clk_out_taps = 4'b0000;
        repeat (3) tick();
        Reset_PD = 1'b0;
        tick();
        tick();
        chk("rst_cnt", int'(dut.cnt), 0);
        chk("rst_up", int'(UP), 0);
        chk("rst_dn", int'(DN), 0);
        chk("rst_lock", int'(LOCK), 0);
        chk("rst_comp", int'(COMP), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_state", int'(dut.state), int'(IDLE));
        DIV_M = 1'b0;
        tick();

        // all-lead window
        ups = 0;
        dns = 0;
        strobe(4'b1111);
        chk("s1_cnt", int'(dut.cnt), 1);
        chk("s1_state", int'(dut.state), int'(ACQUIRE));
        strobes(7, 4'b1111);
        chk("t2_up_edge", int'(up_s), 1);
        chk("t2_ups", ups, 1);
        chk("t2_dns", dns, 0);
        chk("t2_score", int'(score), 8);
        chk("t2_state", int'(dut.state), int'(ACQUIRE));
        chk("t2_comp", int'(COMP), 1);

        // lag window, then non-monotonic sample
        ups = 0;
        dns = 0;
        strobes(5, 4'b0000);
        strobes(3, 4'b0011);
        chk("t3_dn_edge", int'(dn_s), 1);
        chk("t3_dns", dns, 1);
        chk("t3_ups", ups, 0);
        chk("t3_score", int'(score), -5);
        strobe(4'b0101);
        chk("t3_cnt", int'(dut.cnt), 1);
        chk("t3_acc", int'(dut.acc), 0);
        chk("t3_comp", int'(COMP), 1);
        dns = 0;
        strobes(7, 4'b0000);
        chk("t3_fill_dns", dns, 1);
        chk("t3_fill_score", int'(score), -7);

        // four quiet windows to lock
        ups = 0;
        dns = 0;
        for (int w = 0; w < 4; w++) begin
            strobes(3, 4'b1111);
            strobes(5, 4'b0111);
            if (w == 2) chk("t4_lock_w3", int'(LOCK), 0);
        end
        chk("t4_score", int'(score), 3);
        chk("t4_lock", int'(LOCK), 1);
        chk("t4_state", int'(dut.state), int'(LOCKED));
        chk("t4_pulses", ups + dns, 0);
        strobes(5, 4'b1111);
        strobes(3, 4'b0011);
        chk("t4_hyst_score", int'(score), 5);
        chk("t4_hyst_ups", ups, 0);
        chk("t4_hyst_lock", int'(LOCK), 1);
        strobes(8, 4'b1111);
        chk("t4_unlock_up", int'(up_s), 1);
        chk("t4_unlock_lock", int'(lk_s), 0);
        chk("t4_unlock_ups", ups, 1);
        chk("t4_unlock_state", int'(dut.state), int'(ACQUIRE));

        // DIV_M held high, then hold
        ups = 0;
        dns = 0;
        DIV_M        = 1'b1;
        clk_out_taps = 4'b1111;
        repeat (20) tick();
        DIV_M = 1'b0;
        tick();
        chk("t5_held_cnt", int'(dut.cnt), 1);
        chk("t5_held_acc", int'(dut.acc), 1);
        hold = 1'b1;
        strobes(3, 4'b0000);
        chk("t5_hold_cnt", int'(dut.cnt), 1);
        chk("t5_hold_acc", int'(dut.acc), 1);
        chk("t5_hold_comp", int'(COMP), 1);
        chk("t5_hold_pulses", ups + dns, 0);
        hold = 1'b0;
        strobes(7, 4'b1111);
        chk("t5_ups", ups, 1);
        chk("t5_score", int'(score), 8);
        chk("t5_cnt", int'(dut.cnt), 0);

        // reset mid-window with a coincident strobe
        ups = 0;
        dns = 0;
        strobes(5, 4'b1111);
        chk("t6_pre_cnt", int'(dut.cnt), 5);
        Reset_PD = 1'b1;
        DIV_M    = 1'b1;
        tick();
        chk("t6_rst_cnt", int'(dut.cnt), 0);
        chk("t6_rst_acc", int'(dut.acc), 0);
        chk("t6_rst_up", int'(UP), 0);
        chk("t6_rst_state", int'(dut.state), int'(IDLE));
        Reset_PD = 1'b0;
        DIV_M    = 1'b0;
        tick();
        ups = 0;
        strobes(7, 4'b1111);
        chk("t6_no_early_up", ups, 0);
        strobe(4'b1111);
        chk("t6_ups", ups, 1);
        chk("t6_score", int'(score), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
